tdc_interval_core: RTL and testbench
====================================

# tdc_interval_core

Parametrised start/stop measurement core for the next-generation TDC. It takes the pipelined thermometer snapshots of the start and stop delay lines, encodes them bubble-tolerantly, and counts coarse clock periods between a start and up to MAX_STOPS stops. Each measurement is emitted as a record through a result FIFO with a valid/ready handshake. It sits between the start/stop delay-line pipelines and the readout logic, and replaces the separate encoder and counter instances.

## Interface
- N_TAPS, 32: delay-line taps per thermometer input.
- FINE_W, 6: fine-code width; must satisfy 2^FINE_W > N_TAPS.
- COARSE_W, 12: coarse counter width.
- TIMEOUT, 1000: coarse cycles before a session is aborted; 1 ≤ TIMEOUT < 2^COARSE_W.
- MAX_STOPS, 4: stops accepted per start; 1 = single-stop mode.
- FIFO_DEPTH, 8: result FIFO entries, power of two.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- start_hit  in  1  qualifies start_thermo this cycle.
- start_thermo  in  N_TAPS  sampled start-line thermometer code.
- stop_hit  in  1  qualifies stop_thermo this cycle.
- stop_thermo  in  N_TAPS  sampled stop-line thermometer code.
- out_valid  out  1  FIFO head holds a record.
- out_ready  in  1  consumer accepts the head record.
- out_coarse  out  COARSE_W  coarse cycles from start to stop (or TIMEOUT).
- out_fine_start  out  FINE_W  fine code of the start.
- out_fine_stop  out  FINE_W  fine code of the stop; 0 on timeout.
- out_stop_idx  out  clog2(MAX_STOPS), min 1  index of the stop within its session.
- out_timeout  out  1  record is a timeout record.
- busy  out  1  session in progress.
- overflow  out  1  sticky: a record was lost because the FIFO was full.

## Operation
- Fine encoding is the popcount of the thermometer code (0..N_TAPS), which tolerates bubbles. No priority encoding.
- FSM states: IDLE, MEASURE.
- IDLE + start_hit:
  - latch the start fine code;
  - set coarse counter cnt to 1 and stop counter to 0;
  - go to MEASURE.
  - stop_hit in IDLE is ignored, including when it coincides with start_hit.
- MEASURE, each cycle:
  - cnt increments, saturating at TIMEOUT;
  - start_hit is ignored (no retrigger).
- MEASURE + stop_hit: push record {coarse=cnt, fine_start, fine_stop, stop_idx, timeout=0} and increment the stop counter. When the count reaches MAX_STOPS, go to IDLE.
- MEASURE with cnt==TIMEOUT:
  - a stop in that cycle is recorded normally;
  - the session then ends and the FSM goes to IDLE;
  - a timeout record {coarse=TIMEOUT, fine_stop=0, stop_idx=0, timeout=1} is pushed only if the session recorded zero stops.
- At most one push per cycle.
- Push when full: the record is dropped and overflow is set. The full check uses the pre-pop occupancy, so a simultaneous pop does not rescue the push.
- Pop occurs when out_valid && out_ready. out_* must hold stable while out_valid && !out_ready.
- Empty FIFO: out_valid=0 and the data outputs are don't-care (driven 0).
- busy=1 exactly while in MEASURE.

## Timing
- Inputs are registered at the sampling edge, the popcount is registered in stage 2, and the FIFO is written at the stage-2 edge.
- A stop_hit in cycle T with an empty FIFO gives out_valid=1 in cycle T+2.
- Start at cycle S and stop at cycle T gives coarse = T−S.
- Timeout record is visible at cycle S+TIMEOUT+2.
- Back-to-back stops in consecutive cycles are each recorded, giving FIFO throughput of 1 record per cycle.
- A new start is accepted in the cycle after the FSM returns to IDLE.
- Reset, including mid-session:
  - FSM to IDLE, cnt=0, FIFO emptied;
  - out_valid=0, busy=0, overflow=0, all out_* = 0;
  - an in-flight stage-2 record is discarded.

## Structure
- tdc_pkg holds:
  - the state enum (IDLE, MEASURE);
  - the result record struct (coarse, fine_start, fine_stop, stop_idx, timeout);
  - a popcount function;
  - a clog2 width helper.
- Sub-module tdc_result_fifo: synchronous FIFO of records with push/full/pop/empty, parametrised on FIFO_DEPTH, pointers one bit wider than the address.
- The FSM, coarse counter and encoding stay in tdc_interval_core.

## Test plan
- Basic measurement: start at cycle 10 with 0x000000FF, stop at cycle 25 with 0x0000FFFF → at cycle 27 out_valid=1, coarse=15, fine_start=8, fine_stop=16, idx=0, timeout=0.
- Multi-stop:
  - stimulus: start at cycle 0; stops at cycles 3, 7, 8, 20, plus a fifth stop at 30;
  - response: coarse 3/7/8/20 with idx 0..3, busy=0 from cycle 21, the fifth stop ignored.
- Timeout: start at cycle 0 with no stop → at cycle 1002 one record with coarse=1000, timeout=1, fine_stop=0; busy=0 from cycle 1001.
- Full FIFO and backpressure:
  - stimulus: out_ready=0 while 9 records are generated, then drain;
  - response: overflow=1, the 8 oldest records come out in order, the 9th is lost.
- Boundary cases:
  - bubble code 0x000000F7 → fine 7;
  - start and stop in the same IDLE cycle → no record.
- Reset mid-session: reset at cycle 5 after a start at cycle 0, then a stop at cycle 7 → no record, busy=0, out_valid=0.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC start/stop interval core.
package tdc_pkg;

  // Widest thermometer code the popcount helper accepts.
  localparam int POPCNT_W = 256;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Result record at the block's default widths. The FIFO uses it as its
  // default element type; the core overrides it with its own widths.
  typedef struct packed {
    logic [11:0] coarse;
    logic [5:0]  fine_start;
    logic [5:0]  fine_stop;
    logic [1:0]  stop_idx;
    logic        timeout;
  } tdc_rec_t;

  // clog2 with a floor of one bit, for index and counter widths.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bubble-tolerant fine code: the number of set taps.
  function automatic logic [15:0] popcount(input logic [POPCNT_W-1:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < POPCNT_W; i++) c = c + 16'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/tdc_result_fifo.sv
// Synchronous record FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module tdc_result_fifo import tdc_pkg::*; #(
  parameter int  DEPTH = 8,
  parameter type rec_t = tdc_rec_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  rec_t push_data,
  output logic full,
  input  logic pop,
  output logic empty,
  output rec_t head
);

  localparam int AW = idx_width(DEPTH);

  rec_t         mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; a push while full is refused here and reported upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Record storage.
  // NOTE: the array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tdc_interval_core.sv
// Start/stop measurement core: session FSM with coarse counter, a stage-1
// capture register, popcount fine encoding and a result FIFO.
module tdc_interval_core import tdc_pkg::*; #(
  parameter int N_TAPS     = 32,
  parameter int FINE_W     = 6,
  parameter int COARSE_W   = 12,
  parameter int TIMEOUT    = 1000,
  parameter int MAX_STOPS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_hit,
  input  logic [N_TAPS-1:0]                  start_thermo,
  input  logic                               stop_hit,
  input  logic [N_TAPS-1:0]                  stop_thermo,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [COARSE_W-1:0]                out_coarse,
  output logic [FINE_W-1:0]                  out_fine_start,
  output logic [FINE_W-1:0]                  out_fine_stop,
  output logic [idx_width(MAX_STOPS)-1:0]    out_stop_idx,
  output logic                               out_timeout,
  output logic                               busy,
  output logic                               overflow
);

  localparam int IDX_W  = idx_width(MAX_STOPS);
  localparam int SCNT_W = idx_width(MAX_STOPS + 1);

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine_start;
    logic [FINE_W-1:0]   fine_stop;
    logic [IDX_W-1:0]    stop_idx;
    logic                timeout;
  } result_t;

  state_t              state, state_nxt;
  logic [COARSE_W-1:0] cnt, cnt_nxt;
  logic [SCNT_W-1:0]   stop_cnt, stop_cnt_nxt;
  logic [N_TAPS-1:0]   start_code, start_code_nxt;
  logic                rec_push;
  logic                rec_timeout;

  logic                s1_valid;
  logic                s1_timeout;
  logic [COARSE_W-1:0] s1_coarse;
  logic [IDX_W-1:0]    s1_idx;
  logic [N_TAPS-1:0]   s1_start_code;
  logic [N_TAPS-1:0]   s1_stop_code;

  result_t             push_rec;
  result_t             head_rec;
  logic                fifo_full;
  logic                fifo_empty;

  // Session control: start, stop counting, coarse count and timeout.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    stop_cnt_nxt   = stop_cnt;
    start_code_nxt = start_code;
    rec_push       = 1'b0;
    rec_timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (start_hit) begin
          state_nxt      = MEASURE;
          cnt_nxt        = COARSE_W'(1);
          stop_cnt_nxt   = '0;
          start_code_nxt = start_thermo;
        end
      end
      MEASURE: begin
        if (cnt != COARSE_W'(TIMEOUT)) cnt_nxt = cnt + 1'b1;
        if (stop_hit) begin
          rec_push     = 1'b1;
          stop_cnt_nxt = stop_cnt + 1'b1;
          if (stop_cnt_nxt == SCNT_W'(MAX_STOPS)) state_nxt = IDLE;
        end else if (cnt == COARSE_W'(TIMEOUT) && stop_cnt == '0) begin
          rec_push    = 1'b1;
          rec_timeout = 1'b1;
        end
        if (cnt == COARSE_W'(TIMEOUT)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Session state registers.
  // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      stop_cnt   <= '0;
      start_code <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      start_code <= start_code_nxt;
    end
  end

  // Stage-1 valid flag; clearing it on reset discards an in-flight record.
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= rec_push;
  end

  // Stage-1 record payload, qualified by s1_valid.
  always_ff @(posedge clk) begin
    s1_timeout    <= rec_timeout;
    s1_coarse     <= cnt;
    s1_idx        <= IDX_W'(stop_cnt);
    s1_start_code <= start_code;
    s1_stop_code  <= rec_timeout ? '0 : stop_thermo;
  end

  // Stage-2 encoding: popcount of both codes, written into the FIFO.
  always_comb begin
    push_rec.coarse     = s1_coarse;
    push_rec.fine_start = FINE_W'(popcount(POPCNT_W'(s1_start_code)));
    push_rec.fine_stop  = FINE_W'(popcount(POPCNT_W'(s1_stop_code)));
    push_rec.stop_idx   = s1_idx;
    push_rec.timeout    = s1_timeout;
  end

  tdc_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (result_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s1_valid),
    .push_data (push_rec),
    .full      (fifo_full),
    .pop       (out_ready),
    .empty     (fifo_empty),
    .head      (head_rec)
  );

  // Sticky loss flag: full is judged before any same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset)                      overflow <= 1'b0;
    else if (s1_valid && fifo_full) overflow <= 1'b1;
  end

  assign out_valid      = !fifo_empty;
  assign out_coarse     = head_rec.coarse;
  assign out_fine_start = head_rec.fine_start;
  assign out_fine_stop  = head_rec.fine_stop;
  assign out_stop_idx   = head_rec.stop_idx;
  assign out_timeout    = head_rec.timeout;
  assign busy           = (state == MEASURE);

endmodule

// File: tb/tb_tdc_interval_core.sv
// Self-checking bench for tdc_interval_core: directed scenarios plus
// randomized sessions scored against a session-level reference model.
module tb_tdc_interval_core;

  localparam int N_TAPS    = 32;
  localparam int FINE_W    = 6;
  localparam int COARSE_W  = 12;
  localparam int TIMEOUT   = 1000;
  localparam int MAX_STOPS = 4;
  localparam int IDX_W     = 2;

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fs;
    logic [FINE_W-1:0]   fe;
    logic [IDX_W-1:0]    idx;
    logic                to;
  } rec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_hit = 1'b0;
  logic              stop_hit = 1'b0;
  logic              out_ready = 1'b0;
  logic [N_TAPS-1:0] start_thermo = '0;
  logic [N_TAPS-1:0] stop_thermo = '0;
  logic                out_valid;
  logic [COARSE_W-1:0] out_coarse;
  logic [FINE_W-1:0]   out_fine_start;
  logic [FINE_W-1:0]   out_fine_stop;
  logic [IDX_W-1:0]    out_stop_idx;
  logic                out_timeout;
  logic                busy;
  logic                overflow;

  int   n_checks = 0;
  int   n_pass = 0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  tdc_interval_core dut (
    .clk            (clk),
    .reset          (reset),
    .start_hit      (start_hit),
    .start_thermo   (start_thermo),
    .stop_hit       (stop_hit),
    .stop_thermo    (stop_thermo),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_coarse     (out_coarse),
    .out_fine_start (out_fine_start),
    .out_fine_stop  (out_fine_stop),
    .out_stop_idx   (out_stop_idx),
    .out_timeout    (out_timeout),
    .busy           (busy),
    .overflow       (overflow)
  );

  function automatic rec_t head();
    return {out_coarse, out_fine_start, out_fine_stop, out_stop_idx, out_timeout};
  endfunction

  // Reference record straight from the rules: coarse in cycles, fine = set taps.
  function automatic rec_t mk_rec(input int coarse, input logic [N_TAPS-1:0] st,
                                  input logic [N_TAPS-1:0] sp, input int idx, input bit to);
    rec_t r;
    r.coarse = COARSE_W'(coarse);
    r.fs     = FINE_W'($countones(st));
    r.fe     = to ? '0 : FINE_W'($countones(sp));
    r.idx    = IDX_W'(idx);
    r.to     = to;
    return r;
  endfunction

  function automatic logic [N_TAPS-1:0] rand_thermo();
    logic [N_TAPS-1:0] t;
    int k;
    k = $urandom_range(0, N_TAPS);
    t = (k == N_TAPS) ? '1 : ((N_TAPS'(1) << k) - 1'b1);
    if ($urandom_range(0, 3) == 0) t[$urandom_range(0, N_TAPS-1)] ^= 1'b1;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench at cycle 0: reset low, first cycle the DUT sees stimulus.
  task automatic apply_reset();
    reset = 1'b1; start_hit = 1'b0; stop_hit = 1'b0; out_ready = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, overflow} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {out_valid, busy, overflow});
    else n_pass++;
    n_checks++;
    if (head() !== '0) $display("FAIL reset_outputs: got %h expected 0", head());
    else n_pass++;
    tick();
  endtask

  task automatic test_basic();
    rec_t e;
    apply_reset();
    idle(10);
    start_hit = 1'b1; start_thermo = 32'h0000_00FF; tick();
    start_hit = 1'b0;
    idle(14);
    stop_hit = 1'b1; stop_thermo = 32'h0000_FFFF; tick();
    stop_hit = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_latency_c26: got valid %b expected 0", out_valid);
    else n_pass++;
    tick();
    @(negedge clk);
    e = mk_rec(15, 32'h0000_00FF, 32'h0000_FFFF, 0, 0);
    n_checks++;
    if ({out_valid, head()} !== {1'b1, e})
      $display("FAIL basic_record_c27: got %b/%h expected 1/%h", out_valid, head(), e);
    else n_pass++;
    tick();
  endtask

  task automatic test_multi_stop();
    int stops[5] = '{3, 7, 8, 20, 30};
    logic [N_TAPS-1:0] st;
    rec_t e;
    int k;
    apply_reset();
    exp_q.delete();
    st = rand_thermo();
    k = 0;
    for (int c = 0; c <= 34; c++) begin
      start_hit = (c == 0); start_thermo = st;
      stop_hit = 1'b0;
      if (k < 5 && c == stops[k]) begin
        stop_hit = 1'b1; stop_thermo = rand_thermo();
        if (k < MAX_STOPS) exp_q.push_back(mk_rec(c, st, stop_thermo, k, 0));
        k++;
      end
      @(negedge clk);
      if (c == 20) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL multi_busy_c20: got %b expected 1", busy); else n_pass++;
      end
      if (c == 21) begin
        n_checks++;
        if (busy !== 1'b0) $display("FAIL multi_busy_c21: got %b expected 0", busy); else n_pass++;
      end
      tick();
    end
    start_hit = 1'b0; stop_hit = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < MAX_STOPS; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({out_valid, head()} !== {1'b1, e})
        $display("FAIL multi_record_%0d: got %b/%h expected 1/%h", i, out_valid, head(), e);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL multi_fifth_ignored: got valid %b expected 0", out_valid);
    else n_pass++;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    rec_t e;
    apply_reset();
    start_hit = 1'b1; start_thermo = 32'h0000_000F; tick();
    start_hit = 1'b0;
    idle(TIMEOUT - 1);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL timeout_busy_c1000: got %b expected 1", busy); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid} !== 2'b00)
      $display("FAIL timeout_c1001: got busy/valid %b expected 00", {busy, out_valid});
    else n_pass++;
    tick();
    @(negedge clk);
    e = mk_rec(TIMEOUT, 32'h0000_000F, '0, 0, 1);
    n_checks++;
    if ({out_valid, head()} !== {1'b1, e})
      $display("FAIL timeout_record_c1002: got %b/%h expected 1/%h", out_valid, head(), e);
    else n_pass++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL timeout_single_record: got valid %b expected 0", out_valid);
    else n_pass++;
    tick();
  endtask

  // Nine records with out_ready low, plus a tenth pushed while full during a pop.
  task automatic test_full_fifo();
    logic [N_TAPS-1:0] st;
    rec_t e;
    int s0;
    int k;
    apply_reset();
    exp_q.delete();
    s0 = 0; k = 0; st = '0;
    for (int c = 0; c <= 14; c++) begin
      start_hit = 1'b0; stop_hit = 1'b0;
      out_ready = (c == 13);
      if (c == 0 || c == 5 || c == 10) begin
        st = rand_thermo(); start_hit = 1'b1; start_thermo = st; s0 = c; k = 0;
      end else if (c != 13 && c != 14) begin
        stop_hit = 1'b1; stop_thermo = rand_thermo();
        if (exp_q.size() < 8) exp_q.push_back(mk_rec(c - s0, st, stop_thermo, k, 0));
        k++;
      end
      @(negedge clk);
      if (c == 12) begin
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL full_overflow_c12: got %b expected 0", overflow); else n_pass++;
      end
      if (c == 13) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, head()} !== {1'b1, e})
          $display("FAIL full_record_0: got %b/%h expected 1/%h", out_valid, head(), e);
        else n_pass++;
      end
      if (c == 14) begin
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL full_overflow_c14: got %b expected 1", overflow); else n_pass++;
      end
      tick();
    end
    start_hit = 1'b0; stop_hit = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({out_valid, head()} !== {1'b1, e})
        $display("FAIL full_record_%0d: got %b/%h expected 1/%h", i, out_valid, head(), e);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL full_lost_records: got valid %b expected 0", out_valid);
    else n_pass++;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_boundary();
    rec_t e;
    apply_reset();
    start_hit = 1'b1; start_thermo = 32'h0000_00F7;
    stop_hit = 1'b1; stop_thermo = rand_thermo();
    tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL same_cycle_start_stop: got valid %b expected 0", out_valid);
    else n_pass++;
    idle(3);
    stop_hit = 1'b1; stop_thermo = 32'hFF00_FF01; tick();
    stop_hit = 1'b0;
    tick();
    @(negedge clk);
    e = mk_rec(5, 32'h0000_00F7, 32'hFF00_FF01, 0, 0);
    n_checks++;
    if ({out_valid, head()} !== {1'b1, e})
      $display("FAIL bubble_record: got %b/%h expected 1/%h", out_valid, head(), e);
    else n_pass++;
    tick();
  endtask

  // Stop at cycle 4 is still in stage 1 when reset lands at the end of cycle 5.
  task automatic test_reset_mid_session();
    apply_reset();
    start_hit = 1'b1; start_thermo = rand_thermo(); tick();
    start_hit = 1'b0;
    idle(3);
    stop_hit = 1'b1; stop_thermo = rand_thermo(); tick();
    stop_hit = 1'b0;
    reset = 1'b1; tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, overflow, head()} !== '0)
      $display("FAIL reset_mid_c6: got %b%b%b/%h expected 000/0", out_valid, busy, overflow, head());
    else n_pass++;
    tick();
    stop_hit = 1'b1; stop_thermo = rand_thermo(); tick();
    stop_hit = 1'b0;
    idle(1);
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy} !== 2'b00)
      $display("FAIL reset_mid_c9: got valid/busy %b expected 00", {out_valid, busy});
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    bit stim_done;
    stim_done = 1'b0;
    apply_reset();
    exp_q.delete();
    fork
      begin : stim
        int n;
        int gap;
        int off;
        int w;
        logic [N_TAPS-1:0] st;
        for (int s = 0; s < 20; s++) begin
          n = $urandom_range(1, 6);
          for (int g = $urandom_range(0, 3); g > 0; g--) begin
            stop_hit = 1'($urandom_range(0, 1)); stop_thermo = rand_thermo(); tick();
          end
          st = rand_thermo();
          start_hit = 1'b1; start_thermo = st;
          stop_hit = 1'($urandom_range(0, 1)); stop_thermo = rand_thermo();
          tick();
          start_hit = 1'b0; stop_hit = 1'b0; off = 0;
          for (int k = 0; k < n; k++) begin
            gap = $urandom_range(1, 6);
            for (int g = 1; g < gap; g++) begin
              start_hit = (k < MAX_STOPS) ? 1'($urandom_range(0, 1)) : 1'b0;
              start_thermo = rand_thermo();
              tick();
            end
            off += gap;
            start_hit = 1'b0; stop_hit = 1'b1; stop_thermo = rand_thermo();
            if (k < MAX_STOPS) exp_q.push_back(mk_rec(off, st, stop_thermo, k, 0));
            tick();
            stop_hit = 1'b0;
          end
          w = 0;
          while (busy && w < TIMEOUT + 100) begin tick(); w++; end
          n_checks++;
          if (busy !== 1'b0) $display("FAIL rand_session_end_%0d: busy %b expected 0", s, busy);
          else n_pass++;
          idle(2);
          w = 0;
          while (out_valid && w < 200) begin tick(); w++; end
          n_checks++;
          if (out_valid !== 1'b0) $display("FAIL rand_drain_%0d: valid %b expected 0", s, out_valid);
          else n_pass++;
        end
        stim_done = 1'b1;
      end
      begin : cons
        bit   held;
        rec_t held_rec;
        rec_t e;
        int   w;
        held = 1'b0; held_rec = '0; w = 0;
        while (!(stim_done && exp_q.size() == 0) && w < 40000) begin
          @(negedge clk);
          if (held) begin
            n_checks++;
            if ({out_valid, head()} !== {1'b1, held_rec})
              $display("FAIL rand_hold: got %b/%h expected 1/%h", out_valid, head(), held_rec);
            else n_pass++;
          end
          held = 1'b0;
          if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL rand_unexpected: got %h expected none", head());
            else begin
              e = exp_q.pop_front();
              if (head() !== e) $display("FAIL rand_record: got %h expected %h", head(), e);
              else n_pass++;
            end
          end else if (out_valid) begin
            held = 1'b1; held_rec = head();
          end
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          w++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rand_missing: %0d records outstanding expected 0", exp_q.size());
        else n_pass++;
      end
    join
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL rand_overflow: got %b expected 0", overflow);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_stop();
    test_timeout();
    test_full_fifo();
    test_boundary();
    test_reset_mid_session();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
